// File: rtl/xor_deframer_pkg.sv
// Shared types and line-level constants for the XOR parity deframer.
package xor_deframer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/gate_xor.sv
// Two-input XOR primitive; the deframer closes a registered loop around it.
module gate_xor (
  input  logic inp1,
  input  logic inp2,
  output logic out
);

  assign out = inp1 ^ inp2;

endmodule

// File: rtl/xor_parity_deframer.sv
// Serial frame consumer: start, LSB-first data, parity, stop -> parallel word
// with parity/framing status over a valid/ready handshake.
//
// state  | meaning
// IDLE   | line idle, waiting for a start beat
// DATA   | shifting in data bits, running XOR in acc
// PARITY | waiting for the parity beat
// STOP   | waiting for the stop beat
// HOLD   | result presented, waiting for out_ready
module xor_parity_deframer
  import xor_deframer_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_ok,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  state_t                 state;
  logic [DATA_BITS-1:0]   sr;
  logic [CW-1:0]          cnt;
  logic                   acc;
  logic                   acc_next;
  logic                   parity_r;

  gate_xor u_acc_xor (
    .inp1 (acc),
    .inp2 (bit_in),
    .out  (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      acc       <= 1'b0;
      parity_r  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      parity_ok <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bit_valid && bit_in == START_BIT) begin
            state <= DATA;
            acc   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        DATA: begin
          if (bit_valid) begin
            sr  <= {bit_in, sr[DATA_BITS-1:1]};
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= PARITY;
            end
          end
        end

        PARITY: begin
          if (bit_valid) begin
            // acc_next folds the parity bit into the data XOR
            parity_r <= (acc_next == ODD_PARITY);
            state    <= STOP;
          end
        end

        STOP: begin
          if (bit_valid) begin
            data_out  <= sr;
            parity_ok <= parity_r;
            frame_err <= (bit_in != STOP_BIT);
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= HOLD;
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // a start beat coinciding with the handshake begins the next frame
            if (bit_valid && bit_in == START_BIT) begin
              state <= DATA;
              acc   <= 1'b0;
              cnt   <= '0;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (bit_valid) begin
            overrun <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_parity_deframer.sv
// Scoreboard bench: frame tasks queue the expected result, a negedge monitor
// pops and compares on every accepted output.
module tb_xor_parity_deframer;
  import xor_deframer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] data_out;
  logic       parity_ok;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    logic       pok;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  xor_parity_deframer #(.DATA_BITS(8), .ODD_PARITY(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .parity_ok (parity_ok),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: a handshake completes at the next posedge when both are high here
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data_out", int'(data_out), int'(e.d));
        chk("parity_ok", int'(parity_ok), int'(e.pok));
        chk("frame_err", int'(frame_err), int'(e.ferr));
      end
    end
  end

  task automatic beat(input logic b);
    @(posedge clk);
    #1;
    bit_valid = 1'b1;
    bit_in    = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      bit_in    = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input bit gaps, input logic exp_pok, input logic exp_ferr);
    exp_t e;
    e.d = d;
    e.pok = exp_pok;
    e.ferr = exp_ferr;
    exp_q.push_back(e);
    beat(START_BIT);
    for (int i = 0; i < 8; i++) begin
      beat(d[i]);
      if (gaps) begin
        int g;
        g = int'($urandom_range(1, 2));
        idle(g);
        @(negedge clk);
        chk("state_holds_gap", int'(dut.state), int'(DATA_BITS_STATE(i)));
      end
    end
    beat(par);
    beat(stp);
  endtask

  // after the last data bit the FSM has moved on to PARITY
  function automatic state_t DATA_BITS_STATE(input int i);
    return (i == 7) ? PARITY : DATA;
  endfunction

  initial begin
    rst       = 1'b1;
    bit_in    = 1'b1;
    bit_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);

    // 0xA5, correct even parity, back-to-back bits, latency and pulse width
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_before_stop_edge", int'(out_valid), 0);
    idle(1);
    @(negedge clk);
    chk("lat_valid_after_stop", int'(out_valid), 1);
    idle(1);
    @(negedge clk);
    chk("valid_one_cycle", int'(out_valid), 0);
    idle(2);

    // 0x07 with wrong parity and random gaps
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);

    // 0x3C with bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    @(negedge clk);
    chk("data_out_held", int'(data_out), 'h3C);

    // overrun: result not acknowledged while beats keep arriving
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    @(negedge clk);
    chk("hold_valid", int'(out_valid), 1);
    chk("no_overrun_yet", int'(overrun), 0);
    beat(1'b1);
    beat(1'b0);
    beat(1'b1);
    idle(1);
    @(negedge clk);
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_data_kept", int'(data_out), 'h11);
    chk("overrun_state_hold", int'(dut.state), int'(HOLD));
    @(posedge clk);
    #1 out_ready = 1'b1;
    idle(1);
    @(negedge clk);
    chk("ack_clears_valid", int'(out_valid), 0);
    chk("overrun_sticky", int'(overrun), 1);

    // handshake coinciding with the next start beat
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    @(negedge clk);
    chk("b2b_data_held", int'(data_out), 'h5A);

    // reset mid-frame after four data bits
    beat(START_BIT);
    repeat (4) beat(1'b1);
    @(negedge clk);
    chk("busy_mid_frame", int'(busy), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", int'(dut.state), int'(IDLE));
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_data_out", int'(data_out), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    chk("mid_rst_parity_ok", int'(parity_ok), 0);
    chk("mid_rst_frame_err", int'(frame_err), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);

    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xor_parity_deframer.md
Name: xor_parity_deframer

Overview:
- Serial-frame consumer for the XOR primitive. Accumulates a running XOR of the incoming bit stream through a registered `gate_xor` feedback loop, deserialises the frame and checks the parity bit.
- Sits directly downstream of the serial XOR/parity source. Hands a parallel word plus status to the next stage over a valid/ready handshake.

Parameters:
- DATA_BITS, 8, number of data bits per frame (range 2..32).
- ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit, sampled only when bit_valid=1.
- bit_valid  in  1  qualifies bit_in for one cycle.
- out_ready  in  1  downstream accepts the result.
- out_valid  out  1  result held and valid.
- data_out  out  DATA_BITS  deserialised word, LSB received first.
- parity_ok  out  1  parity check passed.
- frame_err  out  1  stop bit was 0.
- overrun  out  1  sticky: a bit arrived while the result was unacknowledged.
- busy  out  1  high in DATA, PARITY and STOP.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; data_out=0, parity_ok=0, frame_err=0, overrun=0, out_valid=0, busy=0; shift register, XOR accumulator and bit counter cleared. Takes priority over everything, including mid-frame: the partial frame is discarded.
- Frame format, one bit per bit_valid beat: start(0), DATA_BITS data (LSB first), parity, stop(1). Idle cycles (bit_valid=0) may appear anywhere; state holds.
- IDLE: a beat with bit_in=0 -> DATA; acc<=0, cnt<=0. A beat with bit_in=1 is ignored (idle line).
- DATA: each beat shifts bit_in into the MSB of the shift register (right shift), sets acc<=acc^bit_in and increments cnt. The beat where cnt==DATA_BITS-1 -> PARITY.
- PARITY: on a beat, parity_r <= ((acc^bit_in) == ODD_PARITY) -> STOP.
- STOP: on a beat, frame_err_r <= ~bit_in -> HOLD. On the same edge, data_out, parity_ok and frame_err load, and out_valid goes 1 on the next cycle.
- Latency: out_valid is visible 1 cycle after the clk edge that samples the stop bit.
- HOLD:
  - out_valid=1; data_out, parity_ok and frame_err are stable.
  - out_ready=1 -> out_valid=0 next cycle.
  - If the same cycle also carries a start-bit beat (bit_valid=1, bit_in=0), go directly to DATA with no bubble. Otherwise go to IDLE.
  - Any beat while out_ready=0 is dropped and sets overrun=1.
- overrun clears only on rst.
- data_out keeps its last value after the handshake until the next frame's STOP.
- busy = (state in {DATA, PARITY, STOP}).
- cnt width = $clog2(DATA_BITS)+1. No wrap: the transition happens at DATA_BITS-1.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Package xor_deframer_pkg:
  - state enum {IDLE, DATA, PARITY, STOP, HOLD}, 3-bit encoding.
  - constants START_BIT=0, STOP_BIT=1.
- Sub-module: instantiate the existing gate_xor (inp1=acc, inp2=bit_in, out=acc_next). Gate the flop load with the beat qualifier.
- All other logic stays in one module.

Test Plan:
- Data 0xA5 (four 1s), ODD_PARITY=0, parity 0, stop 1, bits back-to-back, out_ready=1 -> out_valid pulses 1 cycle, 1 cycle after the stop sample; data_out=0xA5, parity_ok=1, frame_err=0.
- Data 0x07, parity bit 0 (wrong), stop 1, with random bit_valid gaps -> data_out=0x07, parity_ok=0, frame_err=0; state holds across gaps.
- Data 0x3C, correct parity, stop bit 0 -> frame_err=1, parity_ok=1, data_out=0x3C.
- First frame completes with out_ready=0 and 3 beats are sent during HOLD -> overrun=1 sticky, data_out unchanged. Then out_ready=1 -> out_valid=0 next cycle and overrun stays 1.
- HOLD with out_ready=1 and a start beat in the same cycle, then frame 0x5A -> no lost bit, second result data_out=0x5A.
- rst asserted after 4 data bits -> next cycle all outputs 0 and state IDLE. A new frame 0xFF then decodes correctly with parity_ok=1.
